// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, FSM states,
// datapath mux select codes, trap causes and the decoded opcode class.
package rv_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALU_A_RS1 = 2'd0, ALU_A_OLD_PC = 2'd1, ALU_A_ZERO = 2'd2
    } alu_a_sel_t;

    typedef enum logic [1:0] {
        ALU_B_RS2 = 2'd0, ALU_B_IMM = 2'd1, ALU_B_FOUR = 2'd2
    } alu_b_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_ECALL = 2'd2, CAUSE_TIMEOUT = 2'd3
    } cause_t;

    typedef struct packed {
        logic op;
        logic op_imm;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic fence;
        logic system;
    } op_class_t;

endpackage

// File: rtl/rv_op_classify.sv
// Combinational opcode decoder: one-hot instruction class plus an illegal flag
// for any opcode outside RV32I (SYSTEM counts as a known class).
module rv_op_classify
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP:       cls.op     = 1'b1;
            OPC_OP_IMM:   cls.op_imm = 1'b1;
            OPC_LOAD:     cls.load   = 1'b1;
            OPC_STORE:    cls.store  = 1'b1;
            OPC_BRANCH:   cls.branch = 1'b1;
            OPC_JAL:      cls.jal    = 1'b1;
            OPC_JALR:     cls.jalr   = 1'b1;
            OPC_LUI:      cls.lui    = 1'b1;
            OPC_AUIPC:    cls.auipc  = 1'b1;
            OPC_MISC_MEM: cls.fence  = 1'b1;
            OPC_SYSTEM:   cls.system = 1'b1;
            default:      ;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// owns the memory handshake and its timeout, counts retired instructions.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       wb_sel,
    output logic             reg_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       cause
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state;
    cause_t          cause_q;
    logic [TW-1:0]   tcnt;
    logic [CNT_W-1:0] instret_q;
    logic            rst_q;
    op_class_t       cls;
    logic            illegal;
    logic            hs;
    logic            timeout_hit;

    rv_op_classify u_classify (
        .opcode  (opcode),
        .cls     (cls),
        .illegal (illegal)
    );

    always_comb begin
        // A request in flight when rst rises stays up for that cycle and drops the next.
        mem_req     = ((state == ST_FETCH) || (state == ST_MEM)) && !(rst && rst_q);
        hs          = mem_req && mem_ready;
        timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                      (tcnt == TW'(MEM_TIMEOUT - 1));
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        alu_a_sel   = ALU_A_RS1;
        alu_b_sel   = ALU_B_RS2;
        wb_sel      = WB_ALU;
        reg_we      = 1'b0;
        retire      = 1'b0;
        case (state)
            ST_FETCH: begin
                ir_we = hs;
                pc_we = hs;
            end
            ST_EXEC: begin
                if (cls.op) begin
                    alu_b_sel = ALU_B_RS2;
                end else if (cls.op_imm || cls.load || cls.store) begin
                    alu_b_sel = ALU_B_IMM;
                end else if (cls.branch) begin
                    alu_a_sel = ALU_A_OLD_PC;
                    alu_b_sel = ALU_B_IMM;
                    pc_src    = 1'b1;
                    pc_we     = br_taken;
                    retire    = 1'b1;
                end else if (cls.jal || cls.auipc) begin
                    alu_a_sel = ALU_A_OLD_PC;
                    alu_b_sel = ALU_B_IMM;
                    pc_src    = cls.jal;
                    pc_we     = cls.jal;
                end else if (cls.jalr) begin
                    alu_b_sel = ALU_B_IMM;
                    pc_src    = 1'b1;
                    pc_we     = 1'b1;
                end else if (cls.fence) begin
                    retire    = 1'b1;
                end
            end
            ST_MEM: begin
                mem_we = cls.store && mem_req;
                retire = hs && cls.store;
            end
            ST_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
                if (cls.load)                wb_sel = WB_MEM;
                else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
                else if (cls.lui)            wb_sel = WB_IMM;
                else                         wb_sel = WB_ALU;
            end
            default: ;
        endcase
        if (rst) begin
            mem_we = 1'b0;
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            reg_we = 1'b0;
            retire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state     <= ST_FETCH;
            cause_q   <= CAUSE_NONE;
            tcnt      <= '0;
            instret_q <= '0;
        end else begin
            // Every state is entered with mem_req low or right after a handshake, so this also clears on entry.
            tcnt <= (hs || !mem_req) ? '0 : tcnt + TW'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
            case (state)
                ST_FETCH: begin
                    if (hs) begin
                        state <= ST_DECODE;
                    end else if (timeout_hit) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (cls.system) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_ECALL;
                    end else if (illegal) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cls.load || cls.store)        state <= ST_MEM;
                    else if (cls.branch || cls.fence) state <= ST_FETCH;
                    else                              state <= ST_WB;
                end
                ST_MEM: begin
                    if (hs) begin
                        state <= cls.load ? ST_WB : ST_FETCH;
                    end else if (timeout_hit) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                default: state <= ST_TRAP;
            endcase
        end
    end

    assign halted  = (state == ST_TRAP);
    assign cause   = cause_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: per-instruction expected output
// vectors derived from the instruction class, compared every cycle.
module tb_rv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, retire, halted;
    logic [1:0] alu_a_sel, alu_b_sel, wb_sel, cause;
    logic [3:0] instret;

    rv_multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .wb_sel    (wb_sel),
        .reg_we    (reg_we),
        .retire    (retire),
        .instret   (instret),
        .halted    (halted),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       req, we, irwe, pcwe, pcsrc, regwe, ret, halt;
        bit [1:0] asel, bsel, wsel, cause;
        bit       c_req, c_pcsrc, c_alu, c_wb;
    } exp_t;

    int vecs = 0;
    int bad = 0;
    int m_instret = 0;

    function automatic exp_t blank();
        exp_t e;
        e = '{default: 0};
        e.c_req = 1'b1;
        return e;
    endfunction

    function automatic string cls_of(input logic [6:0] o);
        case (o)
            7'b0110011: return "OP";
            7'b0010011: return "OPIMM";
            7'b0000011: return "LOAD";
            7'b0100011: return "STORE";
            7'b1100011: return "BRANCH";
            7'b1101111: return "JAL";
            7'b1100111: return "JALR";
            7'b0110111: return "LUI";
            7'b0010111: return "AUIPC";
            7'b0001111: return "FENCE";
            7'b1110011: return "SYS";
            default:    return "ILL";
        endcase
    endfunction

    task automatic fail_line(input string tag, input string nm, input int act, input int expv);
        bad++;
        $display("FAIL %s %s: got %0d, expected %0d", tag, nm, act, expv);
    endtask

    // One clock cycle: inputs already driven; compare at the falling edge.
    task automatic cyc(input exp_t e, input string tag);
        @(negedge clk);
        vecs++;
        if (e.c_req && mem_req !== e.req) fail_line(tag, "mem_req", int'(mem_req), int'(e.req));
        if (mem_we  !== e.we)    fail_line(tag, "mem_we",  int'(mem_we),  int'(e.we));
        if (ir_we   !== e.irwe)  fail_line(tag, "ir_we",   int'(ir_we),   int'(e.irwe));
        if (pc_we   !== e.pcwe)  fail_line(tag, "pc_we",   int'(pc_we),   int'(e.pcwe));
        if (reg_we  !== e.regwe) fail_line(tag, "reg_we",  int'(reg_we),  int'(e.regwe));
        if (retire  !== e.ret)   fail_line(tag, "retire",  int'(retire),  int'(e.ret));
        if (halted  !== e.halt)  fail_line(tag, "halted",  int'(halted),  int'(e.halt));
        if (cause   !== e.cause) fail_line(tag, "cause",   int'(cause),   int'(e.cause));
        if (e.c_pcsrc && pc_src !== e.pcsrc) fail_line(tag, "pc_src", int'(pc_src), int'(e.pcsrc));
        if (e.c_alu && alu_a_sel !== e.asel) fail_line(tag, "alu_a_sel", int'(alu_a_sel), int'(e.asel));
        if (e.c_alu && alu_b_sel !== e.bsel) fail_line(tag, "alu_b_sel", int'(alu_b_sel), int'(e.bsel));
        if (e.c_wb && wb_sel !== e.wsel)     fail_line(tag, "wb_sel", int'(wb_sel), int'(e.wsel));
        if (int'(instret) !== (m_instret % 16)) fail_line(tag, "instret", int'(instret), m_instret % 16);
        @(posedge clk);
        #1;
        if (e.ret) m_instret = m_instret + 1;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        vecs++;
        if (act !== expv) fail_line("literal", nm, act, expv);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        m_instret = 0;
        for (int i = 1; i < n; i++) begin
            e = blank();
            cyc(e, "reset");
        end
        rst = 1'b0;
    endtask

    task automatic fetch(input int fw, input string tag);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            e = blank();
            e.req = 1'b1;
            cyc(e, tag);
        end
        mem_ready = 1'b1;
        e = blank();
        e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1; e.pcsrc = 1'b0; e.c_pcsrc = 1'b1;
        cyc(e, tag);
        mem_ready = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] opc, input bit taken,
                             input int fw, input int mw, input int ntrap);
        exp_t  e;
        string cl;
        bit    to_mem, to_wb;
        int    wb;
        cl = cls_of(opc);
        fetch(fw, tag);
        opcode = opc;
        br_taken = taken;
        cyc(blank(), tag);
        if (cl == "SYS" || cl == "ILL") begin
            for (int i = 0; i < ntrap; i++) begin
                mem_ready = i[0];
                e = blank();
                e.halt = 1'b1;
                e.cause = (cl == "SYS") ? 2'd2 : 2'd1;
                cyc(e, tag);
            end
            mem_ready = 1'b0;
            return;
        end
        e = blank();
        e.c_alu = 1'b1;
        to_mem = 1'b0; to_wb = 1'b1; wb = 0;
        case (cl)
            "OP":     ;
            "OPIMM":  e.bsel = 2'd1;
            "LOAD":   begin e.bsel = 2'd1; to_mem = 1'b1; wb = 1; end
            "STORE":  begin e.bsel = 2'd1; to_mem = 1'b1; to_wb = 1'b0; end
            "BRANCH": begin
                e.asel = 2'd1; e.bsel = 2'd1; e.pcsrc = 1'b1; e.c_pcsrc = 1'b1;
                e.pcwe = taken; e.ret = 1'b1; to_wb = 1'b0;
            end
            "JAL":    begin e.asel = 2'd1; e.bsel = 2'd1; e.pcwe = 1'b1; e.pcsrc = 1'b1; e.c_pcsrc = 1'b1; wb = 2; end
            "JALR":   begin e.bsel = 2'd1; e.pcwe = 1'b1; e.pcsrc = 1'b1; e.c_pcsrc = 1'b1; wb = 2; end
            "LUI":    begin e.c_alu = 1'b0; wb = 3; end
            "AUIPC":  begin e.asel = 2'd1; e.bsel = 2'd1; end
            "FENCE":  begin e.c_alu = 1'b0; e.ret = 1'b1; to_wb = 1'b0; end
            default:  ;
        endcase
        cyc(e, tag);
        if (to_mem) begin
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                e = blank();
                e.req = 1'b1; e.we = (cl == "STORE");
                cyc(e, tag);
            end
            mem_ready = 1'b1;
            e = blank();
            e.req = 1'b1; e.we = (cl == "STORE"); e.ret = (cl == "STORE");
            cyc(e, tag);
            mem_ready = 1'b0;
        end
        if (to_wb) begin
            e = blank();
            e.regwe = 1'b1; e.ret = 1'b1; e.c_wb = 1'b1; e.wsel = 2'(wb);
            cyc(e, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        do_reset(3);
        chk("instret_after_reset", int'(instret), 0);

        run_instr("addi", 7'b0010011, 1'b0, 0, 0, 0);
        chk("instret_after_addi", int'(instret), 1);
        run_instr("add_fw3", 7'b0110011, 1'b0, 3, 0, 0);
        run_instr("lw", 7'b0000011, 1'b0, 0, 2, 0);
        chk("instret_after_lw", int'(instret), 3);
        run_instr("sw", 7'b0100011, 1'b0, 0, 0, 0);
        run_instr("sw_mw3", 7'b0100011, 1'b0, 1, 3, 0);
        run_instr("beq_nt", 7'b1100011, 1'b0, 0, 0, 0);
        run_instr("beq_t", 7'b1100011, 1'b1, 0, 0, 0);
        run_instr("jal", 7'b1101111, 1'b0, 0, 0, 0);
        run_instr("jalr", 7'b1100111, 1'b0, 2, 0, 0);
        run_instr("lui", 7'b0110111, 1'b0, 0, 0, 0);
        run_instr("auipc", 7'b0010111, 1'b0, 0, 0, 0);
        run_instr("fence", 7'b0001111, 1'b0, 0, 0, 0);
        chk("instret_after_mix", int'(instret), 12);

        // rst during a FETCH handshake: no enables that cycle, request gone the next
        rst = 1'b1; mem_ready = 1'b1;
        e = blank(); e.c_req = 1'b0;
        cyc(e, "rst_fetch");
        m_instret = 0;
        e = blank();
        cyc(e, "rst_fetch_hold");
        rst = 1'b0; mem_ready = 1'b0;
        run_instr("addi_after_rst", 7'b0010011, 1'b0, 0, 0, 0);

        do_reset(2);
        for (int i = 0; i < 15; i++) run_instr("wrap", 7'b0010011, 1'b0, 0, 0, 0);
        chk("instret_at_max", int'(instret), 15);
        run_instr("wrap_last", 7'b0010011, 1'b0, 0, 0, 0);
        chk("instret_wrapped", int'(instret), 0);

        run_instr("illegal", 7'b1111111, 1'b0, 0, 0, 100);
        chk("illegal_halted", int'(halted), 1);
        chk("illegal_cause", int'(cause), 1);
        do_reset(2);
        run_instr("addi_after_trap", 7'b0010011, 1'b0, 0, 0, 0);

        run_instr("ecall", 7'b1110011, 1'b0, 0, 0, 10);
        chk("ecall_cause", int'(cause), 2);
        do_reset(2);

        // rst in the middle of a store's MEM wait
        fetch(0, "sw_rst");
        opcode = 7'b0100011;
        cyc(blank(), "sw_rst");
        e = blank(); e.c_alu = 1'b1; e.bsel = 2'd1;
        cyc(e, "sw_rst");
        e = blank(); e.req = 1'b1; e.we = 1'b1;
        cyc(e, "sw_rst_mem");
        rst = 1'b1;
        e = blank(); e.c_req = 1'b0;
        cyc(e, "sw_rst_cycle");
        m_instret = 0;
        e = blank();
        cyc(e, "sw_rst_dropped");
        rst = 1'b0;

        // memory never answers the fetch
        for (int i = 0; i < 4; i++) begin
            e = blank(); e.req = 1'b1;
            cyc(e, "timeout_wait");
        end
        for (int i = 0; i < 5; i++) begin
            mem_ready = i[0];
            e = blank(); e.halt = 1'b1; e.cause = 2'd3;
            cyc(e, "timeout_trap");
        end
        mem_ready = 1'b0;
        chk("timeout_cause", int'(cause), 3);
        chk("timeout_halted", int'(halted), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
